// File: rtl/parity_pkg.sv
// Shared parity-type encodings and RX frame state type for the parity unit.
package parity_pkg;

  localparam logic [1:0] PAR_EVEN  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DATA   = 2'b01,
    PARITY = 2'b10,
    DONE   = 2'b11
  } rx_state_t;

endpackage

// File: rtl/parity_sel.sv
// Combinational parity selector: XOR-reduces a word and maps it to the bit
// dictated by the parity type (even, odd, mark, space).
module parity_sel
  import parity_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       par_typ,
  output logic             par
);

  logic red_p0;

  assign red_p0 = ^data;

  always_comb begin
    par = 1'b0;
    case (par_typ)
      PAR_EVEN:  par = red_p0;
      PAR_ODD:   par = ~red_p0;
      PAR_MARK:  par = 1'b1;
      PAR_SPACE: par = 1'b0;
      default:   par = 1'b0;
    endcase
  end

endmodule

// File: rtl/parity_unit.sv
// Parity unit: registered TX parity generator plus an independent RX serial
// frame assembler/checker. Both paths share the parity_sel function.
module parity_unit
  import parity_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_valid,
  input  logic                  PAR_EN,
  input  logic [1:0]            PAR_TYP,
  output logic                  par_bit,
  output logic                  par_bit_valid,
  input  logic                  frame_start,
  input  logic                  ser_in,
  input  logic                  sample_valid,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  chk_done,
  output logic                  par_err,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  // ---------------- TX stage p0 -> p1 ----------------
  logic tx_par_p0;

  parity_sel #(.WIDTH(DATA_WIDTH)) u_tx_sel (
    .data    (P_DATA),
    .par_typ (PAR_TYP),
    .par     (tx_par_p0)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      par_bit       <= 1'b0;
      par_bit_valid <= 1'b0;
    end else begin
      par_bit_valid <= Data_valid;
      if (Data_valid && PAR_EN)
        par_bit <= tx_par_p0;
    end
  end

  // ---------------- RX frame state ----------------
  rx_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             acc;
  logic             en_snap;
  logic [1:0]       typ_snap;
  logic             rx_exp;
  logic             last_sample;

  // The accumulator already holds the XOR of all data bits, so a 1-bit
  // selector instance yields the expected parity for the snapshotted type.
  parity_sel #(.WIDTH(1)) u_rx_sel (
    .data    (acc),
    .par_typ (typ_snap),
    .par     (rx_exp)
  );

  assign last_sample = sample_valid && (cnt == LAST_IDX);
  assign busy        = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (!RST)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (frame_start) begin
      state_nxt = DATA;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        DATA:    if (last_sample) state_nxt = en_snap ? PARITY : DONE;
        PARITY:  if (sample_valid) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ---------------- RX datapath ----------------
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt      <= '0;
      acc      <= 1'b0;
      rx_data  <= '0;
      par_err  <= 1'b0;
      chk_done <= 1'b0;
      en_snap  <= 1'b0;
      typ_snap <= PAR_EVEN;
    end else begin
      // Registered alongside the state so the pulse lines up with DONE.
      chk_done <= (state_nxt == DONE);
      if (frame_start) begin
        cnt      <= '0;
        acc      <= 1'b0;
        rx_data  <= '0;
        par_err  <= 1'b0;
        en_snap  <= PAR_EN;
        typ_snap <= PAR_TYP;
      end else begin
        case (state)
          DATA: begin
            if (sample_valid) begin
              for (int i = 0; i < DATA_WIDTH; i++) begin
                if (cnt == CNT_W'(i))
                  rx_data[i] <= ser_in;
              end
              acc <= acc ^ ser_in;
              cnt <= cnt + 1'b1;
            end
          end
          PARITY: begin
            if (sample_valid)
              par_err <= (ser_in != rx_exp);
          end
          default: ;
        endcase
      end
    end
  end

endmodule
